// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - rPLL reset/lock sequencer with timeout, retries and lock qualification
// All logic runs on the reference clock; outputs are registered from the next state.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 27000,
    parameter int LOCK_STABLE    = 1024,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        ST_RST_PLL,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE) ? CNT_MAX_A : LOCK_STABLE;
    localparam int CW        = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [1:0]    RETRY_LIM    = (MAX_RETRIES > 3) ? 2'd3 : 2'(MAX_RETRIES);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    retry_nxt;
    logic [7:0]    loss_nxt;
    logic          lock_ff1, lock_s;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry_cnt;
        loss_nxt  = lock_loss_cnt;
        case (state)
            ST_RST_PLL: begin
                if (cnt == RST_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    // The cycle that detected lock is the first qualified cycle (LOCK_STABLE >= 2).
                    state_nxt = ST_STABLE;
                    cnt_nxt   = CW'(1);
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_nxt = '0;
                    if (retry_cnt < RETRY_LIM) begin
                        retry_nxt = retry_cnt + 2'd1;
                        state_nxt = ST_RST_PLL;
                    end else begin
                        state_nxt = ST_FAIL;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt = ST_RST_PLL;
                    cnt_nxt   = '0;
                    retry_nxt = 2'd0;
                    if (lock_loss_cnt != 8'hFF) begin
                        loss_nxt = lock_loss_cnt + 8'd1;
                    end
                end
            end
            ST_FAIL: begin
                state_nxt = ST_FAIL;
            end
            default: begin
                state_nxt = ST_RST_PLL;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state         <= ST_RST_PLL;
            cnt           <= '0;
            lock_ff1      <= 1'b0;
            lock_s        <= 1'b0;
            pll_reset     <= 1'b1;
            sys_reset     <= 1'b1;
            ready         <= 1'b0;
            fail          <= 1'b0;
            retry_cnt     <= 2'd0;
            lock_loss_cnt <= 8'd0;
        end else begin
            lock_ff1      <= pll_lock;
            lock_s        <= lock_ff1;
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            retry_cnt     <= retry_nxt;
            lock_loss_cnt <= loss_nxt;
            pll_reset     <= (state_nxt == ST_RST_PLL) || (state_nxt == ST_FAIL);
            sys_reset     <= (state_nxt != ST_RUN);
            ready         <= (state_nxt == ST_RUN);
            fail          <= fail || (state_nxt == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed bench for pll_lock_supervisor
// Output vector layout: {pll_reset, sys_reset, ready, fail, retry_cnt, lock_loss_cnt}.
module tb_pll_lock_supervisor;

    logic       clkin = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       pll_reset;
    logic       sys_reset;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int errors = 0;
    int e      = 0;

    typedef struct {
        logic        rst;
        logic        lock;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[$];

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (20),
        .LOCK_STABLE   (8),
        .MAX_RETRIES   (2)
    ) dut (
        .clkin        (clkin),
        .reset        (reset),
        .pll_lock     (pll_lock),
        .pll_reset    (pll_reset),
        .sys_reset    (sys_reset),
        .ready        (ready),
        .fail         (fail),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clkin = ~clkin;

    function automatic logic [13:0] o(input logic pr, input logic sr, input logic rdy,
                                      input logic fl, input logic [1:0] rc, input logic [7:0] lc);
        return {pr, sr, rdy, fl, rc, lc};
    endfunction

    function automatic logic [13:0] outs();
        return {pll_reset, sys_reset, ready, fail, retry_cnt, lock_loss_cnt};
    endfunction

    task automatic step();
        @(posedge clkin);
        #1;
        e++;
    endtask

    task automatic step_to(input int t);
        while (e < t) step();
    endtask

    task automatic chk(input string name, input logic [13:0] exp);
        logic [13:0] act;
        act = outs();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (pr,sr,rdy,fail,retry,loss)", name, act, exp);
        end
    endtask

    initial begin
        logic [13:0] rst_out;
        int bad;
        rst_out  = o(1, 1, 0, 0, 2'd0, 8'd0);
        reset    = 1'b1;
        pll_lock = 1'b0;

        // Test 1: plain bring-up, lock first sampled on edge 11 after release.
        for (int i = 0; i < 2; i++) tbl.push_back('{1'b1, 1'b0, rst_out});
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 1'b0, o(1, 1, 0, 0, 2'd0, 8'd0)});
        for (int i = 0; i < 7; i++) tbl.push_back('{1'b0, 1'b0, o(0, 1, 0, 0, 2'd0, 8'd0)});
        for (int i = 0; i < 9; i++) tbl.push_back('{1'b0, 1'b1, o(0, 1, 0, 0, 2'd0, 8'd0)});
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 1'b1, o(0, 0, 1, 0, 2'd0, 8'd0)});
        for (int i = 0; i < tbl.size(); i++) begin
            reset    = tbl[i].rst;
            pll_lock = tbl[i].lock;
            step();
            chk($sformatf("t1_row%0d", i), tbl[i].exp);
        end

        // Test 2: one-cycle lock drop four cycles into STABLE restarts qualification.
        reset = 1'b1; pll_lock = 1'b0;
        step(); step();
        chk("t2_reset", rst_out);
        reset = 1'b0; e = 0;
        step_to(4);  chk("t2_pll_reset_fall", o(0, 1, 0, 0, 2'd0, 8'd0));
        pll_lock = 1'b1; step_to(10);
        pll_lock = 1'b0; step_to(11);
        pll_lock = 1'b1;
        step_to(14); chk("t2_no_early_run", o(0, 1, 0, 0, 2'd0, 8'd0));
        step_to(20); chk("t2_before_run", o(0, 1, 0, 0, 2'd0, 8'd0));
        step_to(21); chk("t2_run", o(0, 0, 1, 0, 2'd0, 8'd0));

        // Test 4: lock loss in RUN, re-sequence and re-lock.
        pll_lock = 1'b0; e = 0;
        step_to(2);  chk("t4_still_run", o(0, 0, 1, 0, 2'd0, 8'd0));
        step_to(3);  chk("t4_drop_seen", o(1, 1, 0, 0, 2'd0, 8'd1));
        step_to(6);  chk("t4_pulse_end", o(1, 1, 0, 0, 2'd0, 8'd1));
        step_to(7);  chk("t4_wait", o(0, 1, 0, 0, 2'd0, 8'd1));
        pll_lock = 1'b1;
        step_to(16); chk("t4_before_rerun", o(0, 1, 0, 0, 2'd0, 8'd1));
        step_to(17); chk("t4_rerun", o(0, 0, 1, 0, 2'd0, 8'd1));

        // Test 5: reset mid-RUN, then reset with the WAIT_LOCK timer at 10.
        reset = 1'b1; step();
        chk("t5_reset_in_run", rst_out);
        reset = 1'b0; pll_lock = 1'b0; e = 0;
        step_to(14); chk("t5_wait_timer10", o(0, 1, 0, 0, 2'd0, 8'd0));
        reset = 1'b1; step();
        chk("t5_reset_in_wait", rst_out);
        reset = 1'b0; e = 0;

        // Test 3: no lock ever -> three attempts, then FAIL.
        step_to(3);  chk("t3_p1_high", o(1, 1, 0, 0, 2'd0, 8'd0));
        step_to(4);  chk("t3_p1_low", o(0, 1, 0, 0, 2'd0, 8'd0));
        step_to(23); chk("t3_w1_end", o(0, 1, 0, 0, 2'd0, 8'd0));
        step_to(24); chk("t3_p2_start", o(1, 1, 0, 0, 2'd1, 8'd0));
        step_to(27); chk("t3_p2_high", o(1, 1, 0, 0, 2'd1, 8'd0));
        step_to(28); chk("t3_p2_low", o(0, 1, 0, 0, 2'd1, 8'd0));
        step_to(47); chk("t3_w2_end", o(0, 1, 0, 0, 2'd1, 8'd0));
        step_to(48); chk("t3_p3_start", o(1, 1, 0, 0, 2'd2, 8'd0));
        step_to(51); chk("t3_p3_high", o(1, 1, 0, 0, 2'd2, 8'd0));
        step_to(52); chk("t3_p3_low", o(0, 1, 0, 0, 2'd2, 8'd0));
        step_to(71); chk("t3_w3_end", o(0, 1, 0, 0, 2'd2, 8'd0));
        step_to(72); chk("t3_fail", o(1, 1, 0, 1, 2'd2, 8'd0));
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (outs() !== o(1, 1, 0, 1, 2'd2, 8'd0)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL t3_fail_hold: got %0d deviating cycles required 0", bad);
        end

        // Test 6: reset clears FAIL, then a normal bring-up.
        reset = 1'b1; step();
        chk("t6_reset_from_fail", rst_out);
        reset = 1'b0; e = 0;
        step_to(10);
        pll_lock = 1'b1;
        step_to(19); chk("t6_before_run", o(0, 1, 0, 0, 2'd0, 8'd0));
        step_to(20); chk("t6_run", o(0, 0, 1, 0, 2'd0, 8'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
